hazard_stall_ctrl: RTL and testbench

Pipeline control unit that sits directly upstream of the execute-stage forwarding logic. Every cycle it decides which pipeline registers advance, hold, take a bubble, or are flushed. It detects load-use hazards that forwarding cannot cover and sequences the two-access LDI/STI memory phases. It also freezes the pipe on data-memory waits, flushes wrong-path instructions on a taken control transfer, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: decides per cycle which pipeline registers
// advance, hold, bubble or flush. Also sequences LDI/STI two-access memory
// phases and keeps a saturating count of cycles where the PC did not advance.

package hazard_stall_ctrl_pkg;
    localparam int unsigned REG_W = 3;
    localparam int unsigned OP_W  = 4;

    localparam logic [OP_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_LDB  = 4'b0010;
    localparam logic [OP_W-1:0] OP_STB  = 4'b0011;
    localparam logic [OP_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_RTI  = 4'b1000;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OP_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OP_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OP_W-1:0] OP_SHF  = 4'b1101;
    localparam logic [OP_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OP_W-1:0] OP_TRAP = 4'b1111;
endpackage

module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_W-1:0]     id_sr1,
    input  logic [REG_W-1:0]     id_sr2,
    input  logic [REG_W-1:0]     id_dest,
    input  logic                 id_sr1_used,
    input  logic                 id_sr2_used,
    input  logic                 id_dest_used,
    input  logic [OP_W-1:0]      ex_opcode,
    input  logic [REG_W-1:0]     ex_dest,
    input  logic                 ex_regwrite,
    input  logic [OP_W-1:0]      mem_opcode,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 ifetch_resp,
    input  logic                 branch_taken,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 id_ex_bubble,
    output logic                 mem_indirect_phase,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_IND2 = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_WIDTH-1:0] r_stall_count;

    logic w_mem_indirect_op;
    logic w_ex_is_load;
    logic w_dmem_done;
    logic w_mem_stall;
    logic w_src_match;
    logic w_load_use;

    // Hazard detection terms
    always_comb begin
        w_mem_indirect_op = (mem_opcode == OP_LDI) || (mem_opcode == OP_STI);
        w_ex_is_load      = (ex_opcode == OP_LDR) || (ex_opcode == OP_LDB) ||
                            (ex_opcode == OP_LDI);
        w_dmem_done       = dmem_req && dmem_resp;
        // First access of an indirect op always holds the pipe, even with zero wait.
        w_mem_stall       = dmem_req &&
                            (!dmem_resp || ((r_state == ST_RUN) && w_mem_indirect_op));
        w_src_match       = (id_sr1_used  && (id_sr1  == ex_dest)) ||
                            (id_sr2_used  && (id_sr2  == ex_dest)) ||
                            (id_dest_used && (id_dest == ex_dest));
        w_load_use        = !branch_taken && ex_regwrite && w_ex_is_load && w_src_match;
    end

    // Indirect-access phase state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and prioritized pipeline control outputs
    always_comb begin
        w_next_state       = r_state;
        load_pc            = 1'b1;
        load_if_id         = 1'b1;
        load_id_ex         = 1'b1;
        load_ex_mem        = 1'b1;
        load_mem_wb        = 1'b1;
        if_id_flush        = 1'b0;
        id_ex_flush        = 1'b0;
        ex_mem_flush       = 1'b0;
        id_ex_bubble       = 1'b0;
        mem_indirect_phase = (r_state == ST_IND2);

        case (r_state)
            ST_RUN:  if (w_dmem_done && w_mem_indirect_op) w_next_state = ST_IND2;
            ST_IND2: if (w_dmem_done)                      w_next_state = ST_RUN;
            default: w_next_state = ST_RUN;
        endcase

        if (reset) begin
            load_pc            = 1'b0;
            load_if_id         = 1'b0;
            load_id_ex         = 1'b0;
            load_ex_mem        = 1'b0;
            load_mem_wb        = 1'b0;
            if_id_flush        = 1'b1;
            id_ex_flush        = 1'b1;
            ex_mem_flush       = 1'b1;
            mem_indirect_phase = 1'b0;
        end else if (w_mem_stall) begin
            // Whole pipe freezes; a pending branch flush waits for release.
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_load_use) begin
            // Hold fetch/decode one cycle and send a NOP into execute.
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (!ifetch_resp) begin
            // No instruction this cycle: keep PC, feed a NOP into decode.
            load_pc     = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // Saturating count of cycles where the PC did not advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (!load_pc && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_WIDTH'(1);
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboarded bench for hazard_stall_ctrl: directed scenarios then random traffic.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int unsigned CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [2:0]    id_sr1, id_sr2, id_dest, ex_dest;
    logic          id_sr1_used, id_sr2_used, id_dest_used, ex_regwrite;
    logic [3:0]    ex_opcode, mem_opcode;
    logic          dmem_req, dmem_resp, ifetch_resp, branch_taken;
    logic          load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, mem_indirect_phase;
    logic [CW-1:0] stall_count;

    hazard_stall_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_dest(id_dest),
        .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used), .id_dest_used(id_dest_used),
        .ex_opcode(ex_opcode), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
        .mem_opcode(mem_opcode), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .ifetch_resp(ifetch_resp), .branch_taken(branch_taken),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .id_ex_bubble(id_ex_bubble), .mem_indirect_phase(mem_indirect_phase),
        .stall_count(stall_count)
    );

    typedef struct packed {
        logic       rst;
        logic [2:0] sr1, sr2, dst;
        logic       u1, u2, ud;
        logic [3:0] exop;
        logic [2:0] exd;
        logic       exw;
        logic [3:0] memop;
        logic       req, resp, ifr, br;
    } stim_t;

    // loads = {pc, if_id, id_ex, ex_mem, mem_wb}; flush = {if_id, id_ex, ex_mem}
    typedef struct packed {
        logic [4:0]    loads;
        logic [2:0]    flush;
        logic          bubble;
        logic          phase;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    bit   m_second = 1'b0;  // model: next MEM access is the second of an indirect op
    int   m_cnt    = 0;

    function automatic bit is_ind(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    // Reference: apply the priority rules directly to the stimulus
    function automatic exp_t predict(input stim_t s, input bit second, input int cnt);
        exp_t e;
        bit   frozen, hazard;
        frozen = s.req && (!s.resp || (!second && is_ind(s.memop)));
        hazard = s.exw && (s.exop == OP_LDR || s.exop == OP_LDB || s.exop == OP_LDI) &&
                 ((s.u1 && s.sr1 == s.exd) || (s.u2 && s.sr2 == s.exd) ||
                  (s.ud && s.dst == s.exd));
        e.cnt    = CW'(cnt);
        e.phase  = second && !s.rst;
        e.bubble = 1'b0;
        e.flush  = 3'b000;
        e.loads  = 5'b11111;
        if (s.rst) begin
            e.loads = 5'b00000;
            e.flush = 3'b111;
        end else if (frozen) begin
            e.loads = 5'b00000;
        end else if (s.br) begin
            e.flush = 3'b111;
        end else if (hazard) begin
            e.loads  = 5'b00111;
            e.bubble = 1'b1;
        end else if (!s.ifr) begin
            e.loads = 5'b01111;
            e.flush = 3'b100;
        end
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ifr = 1'b1;
        s.memop = OP_ADD;
        s.exop = OP_ADD;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        reset = s.rst; id_sr1 = s.sr1; id_sr2 = s.sr2; id_dest = s.dst;
        id_sr1_used = s.u1; id_sr2_used = s.u2; id_dest_used = s.ud;
        ex_opcode = s.exop; ex_dest = s.exd; ex_regwrite = s.exw;
        mem_opcode = s.memop; dmem_req = s.req; dmem_resp = s.resp;
        ifetch_resp = s.ifr; branch_taken = s.br;
    endtask

    // Drive one cycle, queue its expectation, advance the model
    task automatic apply(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        drive(s);
        e = predict(s, m_second, m_cnt);
        q.push_back(e);
        if (s.rst) begin
            m_second = 1'b0;
            m_cnt    = 0;
        end else begin
            if (s.req && s.resp) begin
                if (m_second)            m_second = 1'b0;
                else if (is_ind(s.memop)) m_second = 1'b1;
            end
            if (!e.loads[4] && m_cnt < CMAX) m_cnt++;
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle
    initial begin
        forever begin
            exp_t e;
            exp_t a;
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                     if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble,
                     mem_indirect_phase, stall_count};
                n_total++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL ctrl t=%0t got loads=%b fl=%b bub=%b ph=%b cnt=%0d want loads=%b fl=%b bub=%b ph=%b cnt=%0d",
                             $time, a.loads, a.flush, a.bubble, a.phase, a.cnt,
                             e.loads, e.flush, e.bubble, e.phase, e.cnt);
                end
            end
        end
    end

    logic [3:0] ex_ops [6];
    logic [3:0] mem_ops[5];

    initial begin
        stim_t s;
        ex_ops  = '{OP_LDR, OP_LDB, OP_LDI, OP_ADD, OP_STR, OP_LDR};
        mem_ops = '{OP_LDI, OP_STI, OP_LDR, OP_ADD, OP_STR};
        s = idle();
        s.rst = 1'b1;
        drive(s);
        apply(s);
        apply(s);

        // Load-use: LDR R1 in EX, ADD R2,R1,R3 in ID
        s = idle(); s.exop = OP_LDR; s.exd = 3'd1; s.exw = 1'b1; s.sr1 = 3'd1; s.u1 = 1'b1;
        s.sr2 = 3'd3; s.u2 = 1'b1;
        apply(s);
        apply(idle());
        apply(idle());

        // LDI with response on the 1st and 3rd request cycles
        s = idle(); s.memop = OP_LDI; s.req = 1'b1; s.resp = 1'b1;
        apply(s);
        s.resp = 1'b0;
        apply(s);
        s.resp = 1'b1;
        apply(s);
        apply(idle());

        // Branch taken together with a matching load-use
        s = idle(); s.br = 1'b1; s.exop = OP_LDB; s.exd = 3'd5; s.exw = 1'b1;
        s.dst = 3'd5; s.ud = 1'b1;
        apply(s);

        // Branch held during a data-memory wait: flush deferred to release
        s = idle(); s.br = 1'b1; s.req = 1'b1; s.resp = 1'b0;
        apply(s);
        apply(s);
        s.req = 1'b0;
        apply(s);

        // Instruction fetch miss for three cycles
        s = idle(); s.ifr = 1'b0;
        repeat (3) apply(s);
        apply(idle());

        // Reset while in IND2
        s = idle(); s.memop = OP_STI; s.req = 1'b1; s.resp = 1'b1;
        apply(s);
        s = idle(); s.rst = 1'b1;
        apply(s);
        apply(idle());
        apply(idle());

        // Saturation: far more stall cycles than the counter can hold
        s = idle(); s.ifr = 1'b0;
        repeat (CMAX + 5) apply(s);
        @(negedge clk);
        n_total++;
        if (stall_count !== 8'hFF) begin
            n_bad++;
            $display("FAIL sat got=%0d want=255", stall_count);
        end
        apply(s);
        @(negedge clk);
        n_total++;
        if (stall_count !== 8'hFF) begin
            n_bad++;
            $display("FAIL sat_hold got=%0d want=255", stall_count);
        end

        // Random traffic biased toward hazards and indirect accesses
        repeat (3000) begin
            s.rst   = ($urandom_range(0, 99) < 2);
            s.sr1   = 3'($urandom_range(0, 3));
            s.sr2   = 3'($urandom_range(0, 3));
            s.dst   = 3'($urandom_range(0, 3));
            s.exd   = 3'($urandom_range(0, 3));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.ud    = 1'($urandom_range(0, 1));
            s.exw   = ($urandom_range(0, 99) < 70);
            s.exop  = ex_ops[$urandom_range(0, 5)];
            s.memop = mem_ops[$urandom_range(0, 4)];
            s.req   = ($urandom_range(0, 99) < 35);
            s.resp  = ($urandom_range(0, 99) < 55);
            s.ifr   = ($urandom_range(0, 99) < 85);
            s.br    = ($urandom_range(0, 99) < 10);
            apply(s);
        end

        repeat (2) @(posedge clk);
        #2;
        n_total++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
